// File: rtl/eth_mmio_arbiter_pkg.sv
// Shared types and constants for the Ethernet MMIO round-robin arbiter.
package eth_mmio_arb_pkg;

  // Widest MMIO data path the command struct can carry; narrower builds zero-fill the top.
  localparam int unsigned MMIO_DW_MAX = 256;

  localparam logic [MMIO_DW_MAX-1:0] TIMEOUT_ERR_DATA = {4{64'hDEAD_DEAD_DEAD_DEAD}};

  typedef struct packed {
    logic                   we;
    logic [15:0]            addr;
    logic [1:0]             op_size;
    logic [MMIO_DW_MAX-1:0] wdata;
  } eth_mmio_cmd_s;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eth_mmio_arb_tag_fifo.sv
// Requester-id FIFO for in-flight reads; push and pop may coincide, even when full.
module eth_mmio_arb_tag_fifo #(
  parameter int unsigned depth_p = 2,
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned ptr_w = (depth_p <= 2) ? 1 : $clog2(depth_p);
  localparam int unsigned cnt_w = $clog2(depth_p + 1);

  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0]   wr_ptr, rd_ptr;
  logic [cnt_w-1:0]   cnt;
  logic               do_push, do_pop;

  assign full_o  = (cnt == cnt_w'(depth_p));
  assign empty_o = (cnt == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem[rd_ptr];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + cnt_w'(1);
        2'b01:   cnt <= cnt - cnt_w'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/eth_mmio_arbiter.sv
// Round-robin arbiter sharing the Ethernet controller MMIO port among num_req_p requesters.
// Define ETH_MMIO_ARB_TIMEOUT_EN to add the read-response watchdog.
module eth_mmio_arbiter
  import eth_mmio_arb_pkg::*;
#(
  parameter int unsigned num_req_p    = 2,
  parameter int unsigned axis_width_p = 64,
  parameter int unsigned max_outst_p  = 2,
  parameter int unsigned timeout_p    = 255
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p-1:0]              req_we_i,
  input  logic [num_req_p*16-1:0]           req_addr_i,
  input  logic [num_req_p*2-1:0]            req_op_size_i,
  input  logic [num_req_p*axis_width_p-1:0] req_wdata_i,
  output logic [axis_width_p-1:0]           resp_data_o,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic                              resp_err_o,
  output logic [15:0]                       addr_o,
  output logic                              write_en_o,
  output logic                              read_en_o,
  output logic [1:0]                        op_size_o,
  output logic [axis_width_p-1:0]           write_data_o,
  input  logic [axis_width_p-1:0]           read_data_i,
  input  logic                              read_data_v_i
);

  localparam int unsigned id_w = id_width(num_req_p);

  logic [id_w-1:0]      rr_ptr, win_id, fifo_head;
  logic                 win_v, fifo_full, fifo_empty;
  logic                 pop_real, pop_any, to_fire;
  logic [num_req_p-1:0] eligible, head_onehot;
  eth_mmio_cmd_s        win_cmd;
  logic                 unused_wdata;

  assign pop_real = read_data_v_i && !fifo_empty;
  assign pop_any  = pop_real || to_fire;

  // A pop in this cycle frees a slot, so a read may still win against a full FIFO.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++)
      eligible[i] = req_v_i[i] && (req_we_i[i] || !fifo_full || pop_any);
  end

  // Scan from farthest to nearest so the first eligible slot after rr_ptr wins.
  always_comb begin
    int unsigned j;
    j      = 0;
    win_v  = 1'b0;
    win_id = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= num_req_p) j = j - num_req_p;
      if (eligible[j]) begin
        win_v  = 1'b1;
        win_id = id_w'(j);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (win_v && reset_n_i) req_ready_o[win_id] = 1'b1;
  end

  always_comb begin
    win_cmd                          = '0;
    win_cmd.we                       = req_we_i[win_id];
    win_cmd.addr                     = req_addr_i[win_id*16 +: 16];
    win_cmd.op_size                  = req_op_size_i[win_id*2 +: 2];
    win_cmd.wdata[axis_width_p-1:0]  = req_wdata_i[win_id*axis_width_p +: axis_width_p];
  end
  assign unused_wdata = ^win_cmd.wdata;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr       <= '0;
      addr_o       <= '0;
      op_size_o    <= '0;
      write_data_o <= '0;
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
    end else begin
      write_en_o <= win_v && win_cmd.we;
      read_en_o  <= win_v && !win_cmd.we;
      if (win_v) begin
        rr_ptr       <= (win_id == id_w'(num_req_p - 1)) ? '0 : win_id + id_w'(1);
        addr_o       <= win_cmd.addr;
        op_size_o    <= win_cmd.op_size;
        write_data_o <= win_cmd.wdata[axis_width_p-1:0];
      end
    end
  end

  eth_mmio_arb_tag_fifo #(
    .depth_p (max_outst_p),
    .width_p (id_w)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (win_v && !win_cmd.we),
    .data_i    (win_id),
    .pop_i     (pop_any),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    head_onehot            = '0;
    head_onehot[fifo_head] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_o    <= '0;
      resp_data_o <= '0;
    end else begin
      resp_v_o <= '0;
      if (pop_real) begin
        resp_v_o    <= head_onehot;
        resp_data_o <= read_data_i;
      end else if (to_fire) begin
        resp_v_o    <= head_onehot;
        resp_data_o <= TIMEOUT_ERR_DATA[axis_width_p-1:0];
      end
    end
  end

`ifdef ETH_MMIO_ARB_TIMEOUT_EN
  localparam int unsigned to_w = $clog2(timeout_p + 1);
  logic [to_w-1:0] wd_cnt;

  // Fires in the cycle the count would reach timeout_p; a real response wins that cycle.
  assign to_fire = !fifo_empty && !pop_real && (wd_cnt == to_w'(timeout_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_cnt     <= '0;
      resp_err_o <= 1'b0;
    end else begin
      resp_err_o <= to_fire;
      if (fifo_empty || pop_any) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + to_w'(1);
    end
  end
`else
  localparam int unsigned unused_timeout = timeout_p;
  assign to_fire    = 1'b0;
  assign resp_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i)
      assert (!(read_data_v_i && fifo_empty))
        else $warning("eth_mmio_arbiter: read response with no read outstanding, dropped");
  end
`endif

endmodule

// File: doc/eth_mmio_arbiter.md
Name: eth_mmio_arbiter

Overview:
- Round-robin arbiter that shares the single MMIO port of the Ethernet controller (addr/write_en/read_en/op_size/write_data, sync read data with valid) between num_req_p requesters, e.g. the host core and a TX/RX DMA engine.
- Each requester sees a private valid/ready command channel and a private read-response valid.
- Read responses are routed back in order through an internal tag FIFO.
- Sits between the requesters and the controller's MMIO decoder, in the controller's clk_i domain.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- axis_width_p, 64, MMIO data width; must match the controller.
- max_outst_p, 2, maximum in-flight reads (tag FIFO depth, power of 2, ≥1).
- timeout_p, 255, response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  num_req_p  per-requester command valid.
- req_ready_o  out  num_req_p  per-requester command accepted this cycle (one-hot or zero).
- req_we_i  in  num_req_p  1 = write, 0 = read.
- req_addr_i  in  num_req_p*16  packed addresses, requester i at [16i+:16].
- req_op_size_i  in  num_req_p*2  packed op sizes.
- req_wdata_i  in  num_req_p*axis_width_p  packed write data.
- resp_data_o  out  axis_width_p  read data, shared by all requesters.
- resp_v_o  out  num_req_p  one-hot read-response valid.
- resp_err_o  out  1  response is a watchdog error (optional feature; constant 0 otherwise).
- addr_o  out  16  to controller addr_i.
- write_en_o  out  1  to controller write_en_i.
- read_en_o  out  1  to controller read_en_i.
- op_size_o  out  2  to controller op_size_i.
- write_data_o  out  axis_width_p  to controller write_data_i.
- read_data_i  in  axis_width_p  from controller read_data_o.
- read_data_v_i  in  1  from controller read_data_v_o.

Behaviour:
- Reset (asynchronous assert, synchronous deassert as seen by the logic):
  - all outputs 0, RR pointer = 0, tag FIFO empty, watchdog counter 0.
  - Commands in flight at reset are dropped; responses arriving in the first cycle after deassertion are ignored (FIFO empty).
- Arbitration (combinational within the cycle):
  - Winner = first i at or after the RR pointer (modulo num_req_p) with req_v_i[i] set and the command eligible.
  - A read is eligible only if the tag FIFO is not full, or a pop occurs in the same cycle. A write is always eligible.
  - Ineligible requesters are skipped; a later eligible one may win.
- Accept:
  - req_ready_o[winner] = 1 for exactly one cycle.
  - RR pointer <= winner+1 (wraps to 0 at num_req_p).
  - No winner means the pointer holds.
  - A requester must hold its command stable while valid and not ready.
- Issue: the accepted command is registered onto addr_o/op_size_o/write_data_o, with write_en_o or read_en_o pulsed high for one cycle the cycle after accept. At most one command is issued per cycle; back-to-back issue is allowed.
- Tag FIFO:
  - Push the winner id on an accepted read.
  - Pop on read_data_v_i.
  - Simultaneous push and pop is allowed, including when full.
  - Id width = max(1, $clog2(num_req_p)).
- Response: on read_data_v_i, resp_data_o <= read_data_i and resp_v_o <= onehot(FIFO head), registered; one cycle added latency.
- read_data_v_i while the FIFO is empty: ignored; assertion fires in simulation.
- Writes generate no response.
- Sustained throughput: one command per cycle with max_outst_p ≥ 2 (controller read latency is 1).

Optional Feature:
- Macro: ETH_MMIO_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs while the FIFO is non-empty and resets on each pop.
  - On reaching timeout_p, the head is force-popped: resp_v_o[head] = 1, resp_data_o = 64'hDEAD_DEAD_DEAD_DEAD (truncated to axis_width_p), resp_err_o = 1.
  - A real response arriving in the same cycle takes precedence and clears the counter.
- Disabled: no counter; resp_err_o tied to 0; timeout_p unused.

Decomposition:
- Package eth_mmio_arb_pkg:
  - eth_mmio_cmd_s struct (we, addr[15:0], op_size[1:0], wdata).
  - Localparam id width function.
  - Timeout error data constant.
- One sub-module: eth_mmio_arb_tag_fifo, a parameterised depth/width FIFO with full/empty and simultaneous push/pop.

Test Plan:
- Requesters 0 and 1 issue continuous writes (req_v_i = 2'b11) -> grants alternate 0,1,0,1; write_en_o high every cycle from cycle 2; addr_o follows each requester's address.
- Requester 1 alone reads addr 16'h0010; controller returns 64'h1234 one cycle after read_en_o -> resp_v_o = 2'b10 and resp_data_o = 64'h1234 two cycles after read_en_o.
- Interleaved reads 0,1,0 with max_outst_p = 2 and controller returns delayed by 3 cycles -> third read stalls (req_ready_o = 0) until the first pop; responses are routed 0,1,0 in order.
- Requester 0 has a read blocked by a full FIFO while requester 1 has a write pending -> requester 1 is granted in the same cycle; requester 0 is granted on the pop cycle.
- Reset asserted with two reads in flight -> all outputs 0 immediately; after release, a stray read_data_v_i produces no resp_v_o.
- With ETH_MMIO_ARB_TIMEOUT_EN and timeout_p = 8: a read never answered -> after 8 cycles, resp_v_o[id] = 1, resp_err_o = 1, data = DEAD pattern, FIFO empty.
